// File: rtl/hfrv_trace_buffer.sv
// hfrv_trace_buffer -- retire-trace capture unit for the HF-RISC core.
//
// Taps the retire/writeback path, classifies each retired RV32I instruction
// by major opcode, and stores a filtered record (pc, instr, rd, wdata) in a
// circular buffer drained through a first-word-fall-through valid/ready port.
//
// Optional build macro: HFRV_TRACE_COVER_EN
//   defined   -> ten saturating per-class retire counters, read via cnt_sel
//   undefined -> counters absent, cnt_value tied to zero
module hfrv_trace_buffer #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 16,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       clear,
   input  logic                       ret_valid,
   input  logic [XLEN-1:0]            ret_pc,
   input  logic [31:0]                ret_instr,
   input  logic [4:0]                 ret_rd,
   input  logic [XLEN-1:0]            ret_wdata,
   input  logic [9:0]                 filter_mask,
   input  logic                       stop_on_full,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [XLEN-1:0]            rd_pc,
   output logic [31:0]                rd_instr,
   output logic [4:0]                 rd_rd,
   output logic [XLEN-1:0]            rd_wdata,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   output logic [CNT_W-1:0]           drop_cnt,
   input  logic [3:0]                 cnt_sel,
   output logic [CNT_W-1:0]           cnt_value
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int NCLS  = 10;

   localparam logic [LVL_W-1:0] LVL_ONE     = LVL_W'(1);
   localparam logic [LVL_W-1:0] LVL_ALMOST  = LVL_W'(DEPTH - 1);

   // Instruction classes, indexed as in filter_mask and the class counters.
   localparam logic [3:0] CLS_LUI    = 4'd0;
   localparam logic [3:0] CLS_AUIPC  = 4'd1;
   localparam logic [3:0] CLS_JAL    = 4'd2;
   localparam logic [3:0] CLS_JALR   = 4'd3;
   localparam logic [3:0] CLS_BRANCH = 4'd4;
   localparam logic [3:0] CLS_LOAD   = 4'd5;
   localparam logic [3:0] CLS_STORE  = 4'd6;
   localparam logic [3:0] CLS_OPIMM  = 4'd7;
   localparam logic [3:0] CLS_OP     = 4'd8;
   localparam logic [3:0] CLS_OTHER  = 4'd9;

   typedef enum logic [1:0] {
      OCC_EMPTY,
      OCC_PARTIAL,
      OCC_FULL
   } occ_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
      logic [4:0]      rd;
      logic [XLEN-1:0] wdata;
   } rec_t;

   function automatic logic [3:0] class_of(input logic [6:0] opcode);
      case (opcode)
         7'b0110111: class_of = CLS_LUI;
         7'b0010111: class_of = CLS_AUIPC;
         7'b1101111: class_of = CLS_JAL;
         7'b1100111: class_of = CLS_JALR;
         7'b1100011: class_of = CLS_BRANCH;
         7'b0000011: class_of = CLS_LOAD;
         7'b0100011: class_of = CLS_STORE;
         7'b0010011: class_of = CLS_OPIMM;
         7'b0110011: class_of = CLS_OP;
         default:    class_of = CLS_OTHER;
      endcase
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   occ_e             occ_q,      occ_d;
   logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
   logic [LVL_W-1:0] level_q,    level_d;
   logic             overflow_q, overflow_d;
   logic [CNT_W-1:0] drop_q,     drop_d;
   logic             mem_we;

   rec_t             mem [DEPTH];
   rec_t             wr_rec;
   rec_t             head_rec;

   logic [3:0]       ret_cls;
   logic             no_wb;
   logic             push;
   logic             pop;

   assign ret_cls = class_of(ret_instr[6:0]);
   assign push    = ret_valid & filter_mask[ret_cls];
   assign rd_valid = (occ_q != OCC_EMPTY);
   assign pop     = rd_valid & rd_ready;

   // Branches and stores have no writeback; an rd of x0 never carries data.
   assign no_wb         = (ret_cls == CLS_BRANCH) || (ret_cls == CLS_STORE);
   assign wr_rec.pc     = ret_pc;
   assign wr_rec.instr  = ret_instr;
   assign wr_rec.rd     = no_wb ? 5'd0 : ret_rd;
   assign wr_rec.wdata  = (no_wb || (ret_rd == 5'd0)) ? '0 : ret_wdata;

   // Occupancy FSM next-state, pointer, level and overflow bookkeeping.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case below can leave a signal unassigned (no latches).
      occ_d      = occ_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      drop_d     = drop_q;
      mem_we     = 1'b0;

      if (clear) begin
         occ_d      = OCC_EMPTY;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         level_d    = '0;
         overflow_d = 1'b0;
         drop_d     = '0;
      end else begin
         case (occ_q)
            OCC_EMPTY: begin
               // Nothing to pop; a push is stored, never bypassed.
               if (push) begin
                  mem_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + PTR_W'(1);
                  level_d  = LVL_ONE;
                  occ_d    = OCC_PARTIAL;
               end
            end

            OCC_PARTIAL: begin
               case ({push, pop})
                  2'b11: begin
                     mem_we   = 1'b1;
                     wr_ptr_d = wr_ptr_q + PTR_W'(1);
                     rd_ptr_d = rd_ptr_q + PTR_W'(1);
                  end
                  2'b10: begin
                     mem_we   = 1'b1;
                     wr_ptr_d = wr_ptr_q + PTR_W'(1);
                     level_d  = level_q + LVL_ONE;
                     if (level_q == LVL_ALMOST) occ_d = OCC_FULL;
                  end
                  2'b01: begin
                     rd_ptr_d = rd_ptr_q + PTR_W'(1);
                     level_d  = level_q - LVL_ONE;
                     if (level_q == LVL_ONE) occ_d = OCC_EMPTY;
                  end
                  default: ;
               endcase
            end

            OCC_FULL: begin
               case ({push, pop})
                  2'b11: begin
                     // The pop frees the slot the push fills: no loss.
                     mem_we   = 1'b1;
                     wr_ptr_d = wr_ptr_q + PTR_W'(1);
                     rd_ptr_d = rd_ptr_q + PTR_W'(1);
                  end
                  2'b10: begin
                     overflow_d = 1'b1;
                     if (stop_on_full) begin
                        if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
                     end else begin
                        // Overwrite the oldest record; both pointers move.
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                     end
                  end
                  2'b01: begin
                     rd_ptr_d = rd_ptr_q + PTR_W'(1);
                     level_d  = level_q - LVL_ONE;
                     occ_d    = OCC_PARTIAL;
                  end
                  default: ;
               endcase
            end

            default: begin
               occ_d    = OCC_EMPTY;
               wr_ptr_d = '0;
               rd_ptr_d = '0;
               level_d  = '0;
            end
         endcase
      end
   end

   // Control state register with asynchronous reset.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge value of every other register.
      if (!reset_n) begin
         occ_q      <= OCC_EMPTY;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         occ_q      <= occ_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
      end
   end

   // Record storage write port.
   always_ff @(posedge clk) begin
      // NOTE: the storage array is deliberately not reset; its contents are
      // never observed while EMPTY because the read data is gated below.
      if (mem_we) mem[wr_ptr_q] <= wr_rec;
   end

   // Head record read, forced to zero while the buffer is empty.
   always_comb begin
      head_rec = rd_valid ? mem[rd_ptr_q] : '0;
   end

   assign rd_pc    = head_rec.pc;
   assign rd_instr = head_rec.instr;
   assign rd_rd    = head_rec.rd;
   assign rd_wdata = head_rec.wdata;
   assign level    = level_q;
   assign overflow = overflow_q;
   assign drop_cnt = drop_q;

`ifdef HFRV_TRACE_COVER_EN
   logic [CNT_W-1:0] cls_cnt_q [NCLS];

   // Per-class retire counters: count every retirement, ignoring the filter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NCLS; i++) cls_cnt_q[i] <= '0;
      end else if (clear) begin
         for (int i = 0; i < NCLS; i++) cls_cnt_q[i] <= '0;
      end else if (ret_valid && (cls_cnt_q[ret_cls] != '1)) begin
         cls_cnt_q[ret_cls] <= cls_cnt_q[ret_cls] + CNT_W'(1);
      end
   end

   // Counter read mux; selects past the last class read zero.
   always_comb begin
      cnt_value = '0;
      if (cnt_sel < 4'(NCLS)) cnt_value = cls_cnt_q[cnt_sel];
   end
`else
   logic cnt_sel_unused;

   assign cnt_sel_unused = ^cnt_sel;
   assign cnt_value      = '0;
`endif

endmodule
